// File: rtl/mem_fifo_ctrl_pkg.sv
// Shared constants and FSM state encoding for the memory-backed FIFO controller.
package mem_fifo_ctrl_pkg;

  localparam int DATA_W = 16;  // data word width
  localparam int DEPTH  = 8;   // words in the attached mem8x16 array
  localparam int PTR_W  = 3;   // array pointer width
  localparam int ADDR_W = 12;  // memory address bus width
  localparam int CNT_W  = 4;   // occupancy counter width, holds 0..DEPTH

  // One memory operation in flight at most: idle, writing in_reg, or reading to out_data.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } state_t;

endpackage

// File: rtl/mem_fifo_ctrl.sv
// FIFO controller in front of an 8x16 gated-row-clock memory array.
// Words enter through a one-word input register, are written into the array,
// read back in order and presented from a registered output word. The array
// control bus is re-timed onto the falling edge so it never changes near a
// rising edge.
module mem_fifo_ctrl #(
  parameter int DATA_W = mem_fifo_ctrl_pkg::DATA_W,
  parameter int DEPTH  = mem_fifo_ctrl_pkg::DEPTH,
  parameter int ADDR_W = mem_fifo_ctrl_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              mem_cs,
  output logic              mem_we,
  output logic              mem_rst
);

  import mem_fifo_ctrl_pkg::*;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Rising-edge state
  state_t             state;
  logic [PTR_W-1:0]   wptr;
  logic [PTR_W-1:0]   rptr;
  logic [CNT_W-1:0]   cnt;
  logic               in_full;
  logic [DATA_W-1:0]  in_reg;
  logic               out_valid_q;
  logic [DATA_W-1:0]  out_data_q;

  // Next-state values, also used by the FSM decision (post-edge view)
  state_t             state_n;
  logic [PTR_W-1:0]   wptr_n;
  logic [PTR_W-1:0]   rptr_n;
  logic [CNT_W-1:0]   cnt_n;
  logic               in_full_n;
  logic [DATA_W-1:0]  in_reg_n;
  logic               out_valid_n;
  logic [DATA_W-1:0]  out_data_n;

  // Falling-edge copies driving the array
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [DATA_W-1:0]  mem_din_q;
  logic               mem_cs_q;
  logic               mem_we_q;

  assign in_ready  = ~in_full;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign count     = cnt;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign mem_cs    = mem_cs_q;
  assign mem_we    = mem_we_q;
  assign mem_rst   = ~rst_n;

  // Complete the op in flight, take handshakes, and pick the next op from post-edge values
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned (which would infer a latch).
    state_n     = IDLE;
    wptr_n      = wptr;
    rptr_n      = rptr;
    cnt_n       = cnt;
    in_full_n   = in_full;
    in_reg_n    = in_reg;
    out_valid_n = out_valid_q;
    out_data_n  = out_data_q;

    unique case (state)
      WR: begin
        wptr_n    = wptr + 1'b1;
        cnt_n     = cnt + 1'b1;
        in_full_n = 1'b0;
      end
      RD: begin
        out_data_n  = mem_dout;
        out_valid_n = 1'b1;
        rptr_n      = rptr + 1'b1;
        cnt_n       = cnt - 1'b1;
      end
      default: ;
    endcase

    // A consumed word frees the output register unless a read lands in it on this same edge.
    if (state != RD && out_valid_q && out_ready)
      out_valid_n = 1'b0;

    // in_ready is low whenever a write is pending, so this never collides with WR completion.
    if (in_valid && in_ready) begin
      in_reg_n  = in_data;
      in_full_n = 1'b1;
    end

    // Refilling the output register wins over draining the input register.
    if (cnt_n != '0 && !out_valid_n)
      state_n = RD;
    else if (in_full_n && cnt_n < FULL_CNT)
      state_n = WR;
    else
      state_n = IDLE;
  end

  // Rising-edge controller state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wptr        <= '0;
      rptr        <= '0;
      cnt         <= '0;
      in_full     <= 1'b0;
      in_reg      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state       <= state_n;
      wptr        <= wptr_n;
      rptr        <= rptr_n;
      cnt         <= cnt_n;
      in_full     <= in_full_n;
      in_reg      <= in_reg_n;
      out_valid_q <= out_valid_n;
      out_data_q  <= out_data_n;
    end
  end

  // Falling-edge copy of the current op onto the array bus, stable across the next rising edge
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_cs_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
    end else begin
      mem_cs_q   <= (state != IDLE);
      mem_we_q   <= (state == WR);
      mem_addr_q <= {{(ADDR_W-PTR_W){1'b0}}, (state == RD) ? rptr : wptr};
      mem_din_q  <= in_reg;
    end
  end

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// Self-checking bench for mem_fifo_ctrl with a behavioural 8x16 array attached.
module tb_mem_fifo_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  count;
  logic [11:0] mem_addr;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;
  logic        mem_cs;
  logic        mem_we;
  logic        mem_rst;

  mem_fifo_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .count    (count),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout),
    .mem_cs   (mem_cs),
    .mem_we   (mem_we),
    .mem_rst  (mem_rst)
  );

  // Array model: write on rising edge with stable control, asynchronous read
  logic [15:0] mem [8];
  always @(posedge clk or posedge mem_rst) begin
    if (mem_rst) begin
      for (int i = 0; i < 8; i++) mem[i] <= '0;
    end else if (mem_cs && mem_we) begin
      mem[mem_addr[2:0]] <= mem_din;
    end
  end
  assign mem_dout = mem[mem_addr[2:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int wa    = 0;
  int ra    = 0;
  int n_rx  = 0;
  logic [15:0] exp_q [$];

  typedef struct {
    logic        iv;
    logic [15:0] id;
    logic        ordy;
    logic        e_irdy;
    logic        e_ov;
    logic [15:0] e_od;
    logic [3:0]  e_cnt;
    logic        e_cs;
    logic        e_we;
    logic [11:0] e_addr;
    logic [15:0] e_din;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_data"},  32'(out_data),  32'd0);
    check({tag, "_count"},     32'(count),     32'd0);
    check({tag, "_mem_cs"},    32'(mem_cs),    32'd0);
    check({tag, "_mem_we"},    32'(mem_we),    32'd0);
    check({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
    check({tag, "_mem_din"},   32'(mem_din),   32'd0);
    check({tag, "_mem_rst"},   32'(mem_rst),   32'd1);
  endtask

  // Push up to n words from base while consuming per mode (0: never, 1: always, 2: toggle 1010...)
  task automatic stream(input int n, input logic [15:0] base, input int mode,
                        input int max_cyc, output int pushed);
    int          sent;
    logic        acc;
    logic        cons;
    logic [15:0] cdat;
    sent = 0;
    for (int c = 0; c < max_cyc; c++) begin
      if (mode != 0 && sent == n && exp_q.size() == 0) break;
      @(negedge clk);
      in_valid  = (sent < n);
      in_data   = base + 16'(sent);
      out_ready = (mode == 1) || (mode == 2 && (c % 2) == 0);
      #1;
      check("addr_hi", 32'(mem_addr[11:3]), 32'd0);
      if (mem_cs && mem_we) begin
        check("wr_addr", 32'(mem_addr), 32'(wa));
        wa = (wa + 1) % 8;
      end
      if (mem_cs && !mem_we) begin
        check("rd_addr", 32'(mem_addr), 32'(ra));
        ra = (ra + 1) % 8;
      end
      acc  = in_valid && in_ready;
      cons = out_valid && out_ready;
      cdat = out_data;
      @(posedge clk);
      if (acc) begin
        exp_q.push_back(in_data);
        sent++;
      end
      if (cons) begin
        n_rx++;
        if (exp_q.size() == 0) check("rx_extra", 32'd1, 32'd0);
        else                   check("rx_data", 32'(cdat), 32'(exp_q.pop_front()));
      end
    end
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (mode != 0) check("drain", 32'(exp_q.size()), 32'd0);
    pushed = sent;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    int seen;

    //           iv    id        ordy  irdy  ov    od        cnt   cs    we    addr     din
    vecs[0] = '{1'b1, 16'hA5A5, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b1, 1'b1, 12'd0, 16'hA5A5};
    vecs[1] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 4'd1, 1'b1, 1'b0, 12'd0, 16'hA5A5};
    vecs[2] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'hA5A5, 4'd0, 1'b0, 1'b0, 12'd1, 16'hA5A5};
    vecs[3] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'hA5A5, 4'd0, 1'b0, 1'b0, 12'd1, 16'hA5A5};
    vecs[4] = '{1'b1, 16'h1234, 1'b1, 1'b0, 1'b0, 16'hA5A5, 4'd0, 1'b1, 1'b1, 12'd1, 16'h1234};
    vecs[5] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'hA5A5, 4'd1, 1'b1, 1'b0, 12'd1, 16'h1234};
    vecs[6] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h1234, 4'd0, 1'b0, 1'b0, 12'd2, 16'h1234};
    vecs[7] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h1234, 4'd0, 1'b0, 1'b0, 12'd2, 16'h1234};

    // Power-on reset
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outs("por");
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Single-word timing and handshake vectors
    for (int i = 0; i < 8; i++) begin
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].id;
      out_ready = vecs[i].ordy;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_in_ready", i),  32'(in_ready),  32'(vecs[i].e_irdy));
      check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      check($sformatf("v%0d_out_data", i),  32'(out_data),  32'(vecs[i].e_od));
      check($sformatf("v%0d_count", i),     32'(count),     32'(vecs[i].e_cnt));
      @(negedge clk);
      #1;
      check($sformatf("v%0d_mem_cs", i),   32'(mem_cs),   32'(vecs[i].e_cs));
      check($sformatf("v%0d_mem_we", i),   32'(mem_we),   32'(vecs[i].e_we));
      check($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
      check($sformatf("v%0d_mem_din", i),  32'(mem_din),  32'(vecs[i].e_din));
    end

    // Mid-run reset while a read is in flight
    in_valid  = 1'b1;
    in_data   = 16'h7777;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("rd_in_flight_cs", 32'(mem_cs), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    wa = 0;
    ra = 0;
    exp_q.delete();
    #1;
    check("midrst_release_mem_rst", 32'(mem_rst), 32'd0);

    // Fill: 12 offered with no consumer, 10 fit
    stream(12, 16'h0001, 0, 40, p);
    check("fill_accepted", 32'(p), 32'd10);
    check("fill_in_ready", 32'(in_ready), 32'd0);
    check("fill_count", 32'(count), 32'd8);
    check("fill_out_valid", 32'(out_valid), 32'd1);
    check("fill_out_data", 32'(out_data), 32'h0001);
    n_rx = 0;
    stream(0, 16'h0000, 1, 100, p);
    check("fill_drained", 32'(n_rx), 32'd10);

    // Wrap: 20 words through the array with a free-running consumer
    n_rx = 0;
    stream(20, 16'h0100, 1, 200, p);
    check("wrap_received", 32'(n_rx), 32'd20);

    // Backpressure: consumer toggles every cycle
    n_rx = 0;
    stream(16, 16'h0200, 2, 300, p);
    check("bp_received", 32'(n_rx), 32'd16);
    check("bp_count", 32'(count), 32'd0);

    // Reset while a write is on the array bus
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'h5A5A;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("wrrst_we_before", 32'(mem_we), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("wrrst_mem_cs", 32'(mem_cs), 32'd0);
    check("wrrst_mem_we", 32'(mem_we), 32'd0);
    check("wrrst_count", 32'(count), 32'd0);
    check("wrrst_out_valid", 32'(out_valid), 32'd0);
    check("wrrst_mem_rst", 32'(mem_rst), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      if (out_valid) seen++;
    end
    check("wrrst_no_emit", 32'(seen), 32'd0);
    check("wrrst_count_after", 32'(count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_fifo_ctrl.md
MEM_FIFO_CTRL -- requirements
Module: mem_fifo_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, data word width.
REQ-002 SHALL have parameter DEPTH, default 8, words in attached mem8x16 array; PTR_W = 3.
REQ-003 SHALL have parameter ADDR_W, default 12, memory address width.
REQ-004 clk  input  1  single clock; all logic clocked by it, both edges (see REQ-014).
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  producer word valid.
REQ-007 in_ready  output  1  controller can accept; equals NOT in_full (registered state).
REQ-008 in_data  input  DATA_W  producer word.
REQ-009 out_valid  output  1  out_data holds an unconsumed word.
REQ-010 out_ready  input  1  consumer accepts out_data.
REQ-011 out_data  output  DATA_W  registered output word.
REQ-012 count  output  4  words stored in memory array, 0..8.
REQ-013 mem_addr  output  ADDR_W; mem_din  output  DATA_W; mem_dout  input  DATA_W; mem_cs, mem_we  output  1; mem_rst  output  1 (= NOT rst_n, active-high array clear).

Function
REQ-014 mem_addr, mem_din, mem_cs, mem_we SHALL be driven from falling-edge flops copying the posedge state, so they are stable across every rising edge (gated-row-clock array).
REQ-015 mem_addr SHALL be {zeros, ptr}; bits [ADDR_W-1:3] always 0; ptr = wptr in WR, rptr in RD.
REQ-016 Input register: in_valid AND in_ready at posedge loads in_reg, sets in_full.
REQ-017 FSM states IDLE, WR, RD; one memory op in flight at most; state updates at posedge.
REQ-018 WR: mem_cs=1, mem_we=1, mem_din=in_reg; at next posedge wptr+1 (mod 8), count+1, in_full cleared.
REQ-019 RD: mem_cs=1, mem_we=0; at next posedge out_data <= mem_dout, out_valid=1, rptr+1 (mod 8), count-1.
REQ-020 IDLE: mem_cs=0, mem_we=0.
REQ-021 Next state uses post-edge values: RD if count_next>0 AND out_valid_next=0; else WR if in_full_next AND count_next<8; else IDLE. RD has priority over WR.
REQ-022 out_valid cleared at posedge when out_valid AND out_ready, unless same edge loads a new word (RD completion keeps it 1).
REQ-023 Latency: word accepted at posedge N with empty storage appears with out_valid=1 after posedge N+2.
REQ-024 Full: count=8 blocks WR; in_full stays 1, in_ready=0; total capacity 10 (8 array + in_reg + out_data).
REQ-025 Empty: count=0 blocks RD; out_valid stays as is.
REQ-026 Data order SHALL be strictly FIFO across pointer wrap 7->0.

Reset
REQ-027 rst_n low SHALL immediately: state IDLE, wptr=rptr=0, count=0, in_full=0 (in_ready=1), out_valid=0, out_data=0, mem_cs=0, mem_we=0, mem_addr=0, mem_din=0, mem_rst=1.
REQ-028 Reset during WR/RD aborts the op; all stored and in-flight words are discarded.
REQ-029 Normal operation resumes on first posedge after rst_n deasserts.

Structure
REQ-030 Shared package SHALL hold DATA_W, DEPTH, PTR_W, ADDR_W constants and the state enum {IDLE, WR, RD}.
REQ-031 Single module, no sub-modules; mem8x16 instantiated alongside it by the parent.

Verification
REQ-032 Reset: rst_n=0 mid-run -> all outputs per REQ-027 same cycle, mem_rst=1.
REQ-033 Single word: push 16'hA5A5 at edge N, out_ready=0 -> write addr 0 at N+1, out_valid=1, out_data=16'hA5A5 after N+2, count=0.
REQ-034 Fill: out_ready=0, offer 0x0001..0x000C -> 10 accepted, in_ready=0, count=8; then out_ready=1 -> 0x0001..0x000A in order.
REQ-035 Wrap: stream 0x0100..0x0113 with out_ready=1 -> 20 words in order, addresses cycle 0..7 twice+, mem_addr[11:3]=0 throughout.
REQ-036 Reset in WR: rst_n=0 while mem_we=1 -> mem_cs=mem_we=0 immediately, count=0, out_valid=0, no word emitted after release.
REQ-037 Backpressure: out_ready toggled 1010... while pushing 16 words -> no loss, no duplicate, order kept.
